// File: rtl/prio_encoder8x3_pkg.sv
// rtl/prio_encoder8x3_pkg.sv - shared widths and helpers for the 8-line priority encoder
// Purpose: line count, code width and half width shared by the encoder files,
//          plus a helper that turns a code back into its one-hot line mask.
// Ports:   none (package)
package prio_encoder8x3_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;
  localparam int HALF_W  = 4;

  function automatic logic [N_LINES-1:0] line_onehot(input logic [CODE_W-1:0] idx);
    logic [N_LINES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_encoder8x3_enc4.sv
// rtl/prio_encoder8x3_enc4.sv - 4-input highest-index-wins priority encoder
// Purpose: combinational 4-to-2 priority encoder, highest set bit wins.
// Ports:   i_vec  in  4  request vector
//          o_idx  out 2  index of highest set bit (0 when none set)
//          o_any  out 1  at least one bit of i_vec is set
module prio_encoder4x2
  import prio_encoder8x3_pkg::*;
(
  input  logic [HALF_W-1:0] i_vec,
  output logic [1:0]        o_idx,
  output logic              o_any
);

  always_comb begin
    o_any = |i_vec;
    o_idx = 2'd0;
    if (i_vec[3])      o_idx = 2'd3;
    else if (i_vec[2]) o_idx = 2'd2;
    else if (i_vec[1]) o_idx = 2'd1;
  end

endmodule

// File: rtl/prio_encoder8x3.sv
// rtl/prio_encoder8x3.sv - 8-line pending-request priority encoder with output register
// Purpose: latches request pulses into a pending set, issues the highest pending
//          line as a 3-bit code through a valid/ready output register, and flags
//          requests that arrive for a line that is already pending.
// Ports:   clk        in  1  clock, all state on rising edge
//          rst        in  1  asynchronous active-high reset
//          req        in  8  request pulses, bit n = line n
//          en         in  1  allows new codes to load into the output register
//          out_ready  in  1  consumer accepts the held code this cycle
//          code       out 3  index of the issued line
//          valid      out 1  code holds an unconsumed index
//          pending    out 8  requests not yet issued
//          dup        out 1  sticky duplicate-request flag
module prio_encoder8x3
  import prio_encoder8x3_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] req,
  input  logic               en,
  input  logic               out_ready,
  output logic [CODE_W-1:0]  code,
  output logic               valid,
  output logic [N_LINES-1:0] pending,
  output logic               dup
);

  logic [N_LINES-1:0] r_pending;
  logic [CODE_W-1:0]  r_code;
  logic               r_valid;
  logic               r_dup;

  logic [1:0]         w_hi_idx;
  logic [1:0]         w_lo_idx;
  logic               w_hi_any;
  logic               w_lo_any;
  logic [CODE_W-1:0]  w_sel_code;
  logic               w_load;
  logic [N_LINES-1:0] w_clear;

  prio_encoder4x2 u_enc_hi (
    .i_vec (r_pending[N_LINES-1:HALF_W]),
    .o_idx (w_hi_idx),
    .o_any (w_hi_any)
  );

  prio_encoder4x2 u_enc_lo (
    .i_vec (r_pending[HALF_W-1:0]),
    .o_idx (w_lo_idx),
    .o_any (w_lo_any)
  );

  // Any upper-half line outranks every lower-half line, so the upper any flag
  // is both code[2] and the mux select for the low two bits.
  assign w_sel_code = {w_hi_any, (w_hi_any ? w_hi_idx : w_lo_idx)};

  // Load only when the register is empty or its code is leaving this edge.
  assign w_load  = en && (w_hi_any || w_lo_any) && (!r_valid || out_ready);
  assign w_clear = w_load ? line_onehot(w_sel_code) : '0;

  // A new request on the line being issued re-arms it (set wins over clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~w_clear) | req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_code  <= w_sel_code;
      r_valid <= 1'b1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // A request on the line being cleared this edge is a re-arm, not a duplicate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_dup <= 1'b0;
    else if (|(req & r_pending & ~w_clear)) r_dup <= 1'b1;
  end

  assign code    = r_code;
  assign valid   = r_valid;
  assign pending = r_pending;
  assign dup     = r_dup;

endmodule

// File: tb/tb_prio_encoder8x3.sv
// tb/tb_prio_encoder8x3.sv - scoreboard bench for the 8-line priority encoder
module tb_prio_encoder8x3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       en;
  logic       out_ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       dup;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  logic [7:0] m_pend;
  logic       m_valid;
  logic       m_dup;

  always #5 clk = ~clk;

  prio_encoder8x3 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .en        (en),
    .out_ready (out_ready),
    .code      (code),
    .valid     (valid),
    .pending   (pending),
    .dup       (dup)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumption monitor: each accepted code must be the oldest issued one.
  always @(negedge clk) begin
    if (!rst && valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) check("code_unexpected", 32'(code), 32'hFFFF_FFFF);
      else                   check("code_order", 32'(code), 32'(exp_q.pop_front()));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_valid",   32'(valid),   32'h0);
    check("rst_code",    32'(code),    32'h0);
    check("rst_dup",     32'(dup),     32'h0);
    exp_q.delete();
    m_pend  = 8'h00;
    m_valid = 1'b0;
    m_dup   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock of stimulus with the reference model advanced alongside:
  // the highest pending line is issued whenever the slot is free and enabled.
  task automatic step(input logic [7:0] r, input logic e, input logic o);
    int         top;
    logic       load;
    logic [7:0] clr;
    req       = r;
    en        = e;
    out_ready = o;
    @(posedge clk);
    top = -1;
    for (int i = 7; i >= 0; i--)
      if (m_pend[i] && top < 0) top = i;
    load = e && (top >= 0) && (!m_valid || o);
    clr  = 8'h00;
    if (load) begin
      clr[top] = 1'b1;
      exp_q.push_back(top);
    end
    if ((r & m_pend & ~clr) != 8'h00) m_dup = 1'b1;
    m_pend = (m_pend & ~clr) | r;
    if (load)   m_valid = 1'b1;
    else if (o) m_valid = 1'b0;
    #1;
    check("model_pending", 32'(pending), 32'(m_pend));
    check("model_valid",   32'(valid),   32'(m_valid));
    check("model_dup",     32'(dup),     32'(m_dup));
  endtask

  initial begin
    req       = 8'h00;
    en        = 1'b0;
    out_ready = 1'b0;
    do_reset();

    // single request on line 3
    step(8'h08, 1'b1, 1'b1);
    check("single_pend", 32'(pending), 32'h08);
    step(8'h00, 1'b1, 1'b1);
    check("single_code",  32'(code),    32'd3);
    check("single_valid", 32'(valid),   32'd1);
    check("single_clear", 32'(pending), 32'h00);
    step(8'h00, 1'b1, 1'b1);
    check("single_idle", 32'(valid), 32'd0);

    // priority drain 7, 4, 0
    step(8'h91, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    check("drain_7", 32'(code), 32'd7);
    step(8'h00, 1'b1, 1'b1);
    check("drain_4", 32'(code), 32'd4);
    step(8'h00, 1'b1, 1'b1);
    check("drain_0", 32'(code), 32'd0);
    step(8'h00, 1'b1, 1'b1);
    check("drain_idle", 32'(valid), 32'd0);

    // stall with code 5 held while line 7 arrives
    step(8'h20, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    check("stall_load5", 32'(code), 32'd5);
    repeat (4) begin
      step(8'h80, 1'b1, 1'b0);
      check("stall_hold5", 32'(code),       32'd5);
      check("stall_p7",    32'(pending[7]), 32'd1);
    end
    step(8'h00, 1'b1, 1'b1);
    check("stall_issue7", 32'(code), 32'd7);
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);

    // reset mid-stream with pending=A5 and a valid code
    step(8'hA5, 1'b1, 1'b0);
    step(8'h80, 1'b1, 1'b0);
    check("pre_rst_pend",  32'(pending), 32'hA5);
    check("pre_rst_valid", 32'(valid),   32'd1);
    do_reset();

    // duplicate while line 2 is pending and not loaded
    step(8'h04, 1'b0, 1'b1);
    step(8'h04, 1'b0, 1'b1);
    check("dup_set", 32'(dup), 32'd1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    check("dup_sticky", 32'(dup), 32'd1);
    do_reset();

    // request on its own load edge: set wins, code 2 twice, no dup
    step(8'h04, 1'b1, 1'b1);
    step(8'h04, 1'b1, 1'b1);
    check("setwin_pend", 32'(pending), 32'h04);
    check("setwin_code", 32'(code),    32'd2);
    check("setwin_dup",  32'(dup),     32'd0);
    step(8'h00, 1'b1, 1'b1);
    check("setwin_code2", 32'(code),    32'd2);
    check("setwin_empty", 32'(pending), 32'h00);
    step(8'h00, 1'b1, 1'b1);

    // enable gating
    step(8'h06, 1'b0, 1'b1);
    repeat (3) step(8'h00, 1'b0, 1'b1);
    check("en_hold_pend",  32'(pending), 32'h06);
    check("en_hold_valid", 32'(valid),   32'd0);
    step(8'h00, 1'b1, 1'b1);
    check("en_code2", 32'(code), 32'd2);
    step(8'h00, 1'b1, 1'b1);
    check("en_code1", 32'(code), 32'd1);
    step(8'h00, 1'b1, 1'b1);
    check("en_idle", 32'(valid), 32'd0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom);
      step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    repeat (12) step(8'h00, 1'b1, 1'b1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
